draw_scheduler: RTL and testbench
=================================

Name: draw_scheduler

Overview:
- Sequences all sprite operations onto the single shared `draw` engine, which feeds the one VGA adapter.
- Four game-logic requesters post operations: erase garbage, draw garbage, erase press, draw press.
- The block latches and arbitrates these requests, then drives the drawer's item/erase/position inputs with a start pulse.
- It holds those inputs stable for the sprite's fixed pixel-cycle length, acknowledges completion, and lets game logic run without cycle-wait loops.

Parameters:
- GARB_CYCLES, 401, drawer cycles to draw or erase one garbage sprite.
- PRESS_CYCLES, 2401, drawer cycles to draw or erase one press sprite.
- CNT_W, 12, busy-counter width; must satisfy 2^CNT_W >= max(GARB_CYCLES, PRESS_CYCLES).

Ports:
- CLOCK_50  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- req  in  4  request strobes; index 0=erase garbage, 1=draw garbage, 2=erase press, 3=draw press.
- req_pos  in  8  packed positions; requester i uses [2i+1:2i], sampled together with req[i].
- ack  out  4  one-cycle completion pulse per requester.
- busy  out  1  high while in any state other than IDLE.
- drw_item  out  1  0=garbage sprite, 1=press sprite.
- drw_erase  out  1  1=erase (paint black), 0=draw.
- drw_position  out  2  lane 0-3 passed to the drawer.
- drw_go  out  1  one-cycle start pulse to the drawer.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; pending, pos latches, counter, ack, drw_go, drw_item, drw_erase, drw_position all 0.
  - A reset during an operation aborts it: no ack is issued and the drawer sees no further go.
- Pending latches:
  - On an edge with req[i]=1, pending[i] is set and pos[i] is loaded from req_pos.
  - A repeat request while pending overwrites pos[i] (last wins) and does not queue a second operation.
  - pending[i] is cleared on the edge that grants i. If req[i] is high on that same edge, set wins and pending stays 1 with the new position.
- Item/erase mapping is fixed:
  - req0 → item=0, erase=1.
  - req1 → item=0, erase=0.
  - req2 → item=1, erase=1.
  - req3 → item=1, erase=0.
  - Length L = GARB_CYCLES for item 0, PRESS_CYCLES for item 1.
- FSM:
  - IDLE: if any pending, grant g = lowest pending index (fixed priority), register drw_* from the mapping and pos[g], load counter=L-1, go to ISSUE. Otherwise stay.
  - ISSUE: drw_go=1 for exactly this cycle; go to WAIT. If L=1, go straight to DONE.
  - WAIT: decrement counter; when counter==1 on an edge, go to DONE. WAIT spans L-1 cycles.
  - DONE: ack[g]=1 for this cycle only; go to IDLE.
- Timing:
  - If the go cycle is t, ack[g] is high in cycle t+L.
  - A request first sampled at edge k produces drw_go in the cycle after edge k+1 when the FSM is IDLE.
  - Back-to-back operations: the next drw_go comes 2 cycles after the previous ack (DONE→IDLE→ISSUE).
- Output hold: drw_item/drw_erase/drw_position hold their last values after DONE until the next grant. The drawer inputs never glitch mid-operation.
- Requests arriving during ISSUE/WAIT/DONE are latched and served afterwards. Nothing is lost or dropped, except same-index coalescing.
- busy=1 in ISSUE, WAIT and DONE.

Optional Feature:
- Macro: DRAW_SCHED_RR_EN.
- Defined: round-robin grant.
  - A 2-bit pointer resets to 0.
  - IDLE grants the first pending index searching upward from the pointer, wrapping 3→0.
  - After granting g, the pointer becomes (g+1) mod 4.
- Undefined: fixed priority, index 0 highest. No pointer register exists.

Test Plan:
- Reset, then a single req[3] with pos=2 → one drw_go pulse with item=1, erase=0, position=2; ack[3] exactly 2401 cycles after go; busy low the next cycle.
- req[1] pos=1 and req[2] pos=3 on the same edge → garbage draw first (item 0, erase 0, pos 1), ack[1] at go+401; second go (item 1, erase 1, pos 3) 2 cycles after ack[1]; ack[2] at that go+2401.
- req[3] pos=0, then req[3] pos=3 two cycles later, both during an unrelated 2401-cycle operation → exactly one draw-press operation at position 3 and one ack[3].
- Assert reset mid-WAIT (cycle go+100) → all outputs 0 immediately (asynchronously), no ack; after release, req[0] pos=1 is served normally with ack[0] at go+401.
- req[1] re-asserted on the same edge it is granted → current op completes with ack[1]; a second garbage op follows with the new position.
- All four req held high continuously → without DRAW_SCHED_RR_EN, grant sequence 0,0,0…; with it defined, 0,1,2,3,0.

Source files
------------

// File: rtl/draw_scheduler_if.sv
// draw_scheduler_if: request/acknowledge and drawer-control bundle between
// game logic (master) and the draw scheduler (slave).
interface draw_scheduler_if;
    logic [3:0] req;
    logic [7:0] req_pos;
    logic [3:0] ack;
    logic       busy;
    logic       drw_item;
    logic       drw_erase;
    logic [1:0] drw_position;
    logic       drw_go;

    modport master (
        output req, req_pos,
        input  ack, busy, drw_item, drw_erase, drw_position, drw_go
    );

    modport slave (
        input  req, req_pos,
        output ack, busy, drw_item, drw_erase, drw_position, drw_go
    );
endinterface

// File: rtl/draw_scheduler.sv
// draw_scheduler: latches sprite requests from four game-logic requesters
// and serialises them onto the single shared drawer. Each operation gets a
// one-cycle go pulse, stable drawer inputs for the sprite length, and a
// one-cycle ack back to its requester.
// Optional macro DRAW_SCHED_RR_EN switches the grant from fixed priority
// (index 0 highest) to round-robin.
module draw_scheduler #(
    parameter int GARB_CYCLES  = 401,
    parameter int PRESS_CYCLES = 2401,
    parameter int CNT_W        = 12
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    draw_scheduler_if.slave bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [CNT_W-1:0] GARB_LOAD  = CNT_W'(GARB_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);

    logic [1:0]       state;
    logic [3:0]       pending;
    logic [1:0]       pos_q [4];
    logic [CNT_W-1:0] count;
    logic [1:0]       grant_q;
    logic [3:0]       ack_q;
    logic             go_q;
    logic             item_q;
    logic             erase_q;
    logic [1:0]       position_q;

    logic             grant_valid;
    logic [1:0]       grant_idx;
    logic             grant_fire;

    assign grant_valid = |pending;
    assign grant_fire  = (state == IDLE) && grant_valid;

`ifdef DRAW_SCHED_RR_EN
    logic [1:0] rr_ptr;
    logic [1:0] cand;
    logic       found;

    // Round-robin pick: first pending index at or after the pointer, wrapping.
    always_comb begin
        grant_idx = rr_ptr;
        cand      = 2'd0;
        found     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr + 2'(k);
            if (!found && pending[cand]) begin
                grant_idx = cand;
                found     = 1'b1;
            end
        end
    end

    // Pointer moves just past whichever requester was granted.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rr_ptr <= 2'd0;
        end else if (grant_fire) begin
            rr_ptr <= grant_idx + 2'd1;
        end
    end
`else
    // Fixed priority pick: the lowest pending index wins.
    always_comb begin
        grant_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (pending[k]) begin
                grant_idx = 2'(k);
            end
        end
    end
`endif

    // Request latches: a new request always wins over the grant clear, and a
    // repeat request simply refreshes the stored position.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pending <= 4'd0;
            for (int k = 0; k < 4; k++) begin
                pos_q[k] <= 2'd0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (bus.req[k]) begin
                    pending[k] <= 1'b1;
                    pos_q[k]   <= bus.req_pos[2*k +: 2];
                end else if (grant_fire && (grant_idx == 2'(k))) begin
                    pending[k] <= 1'b0;
                end
            end
        end
    end

    // Operation sequencer: grant, pulse go, hold for the sprite length, ack.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            grant_q    <= 2'd0;
            ack_q      <= 4'd0;
            go_q       <= 1'b0;
            item_q     <= 1'b0;
            erase_q    <= 1'b0;
            position_q <= 2'd0;
        end else begin
            ack_q <= 4'd0;
            go_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        grant_q    <= grant_idx;
                        item_q     <= grant_idx[1];
                        erase_q    <= ~grant_idx[0];
                        position_q <= pos_q[grant_idx];
                        count      <= grant_idx[1] ? PRESS_LOAD : GARB_LOAD;
                        go_q       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (count == '0) begin
                        ack_q <= 4'b0001 << grant_q;
                        state <= DONE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        ack_q <= 4'b0001 << grant_q;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack          = ack_q;
    assign bus.busy         = (state != IDLE);
    assign bus.drw_go       = go_q;
    assign bus.drw_item     = item_q;
    assign bus.drw_erase    = erase_q;
    assign bus.drw_position = position_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// tb_draw_scheduler: directed and random request traffic for draw_scheduler,
// compared every cycle against a timestamp-based transaction model.
// Honours DRAW_SCHED_RR_EN the same way the design does.
module tb_draw_scheduler;

    localparam int GARB_CYCLES  = 401;
    localparam int PRESS_CYCLES = 2401;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;

    draw_scheduler_if bus ();

    draw_scheduler #(
        .GARB_CYCLES (GARB_CYCLES),
        .PRESS_CYCLES(PRESS_CYCLES),
        .CNT_W       (12)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int compare_count  = 0;
    int mismatch_count = 0;

    // Reference model: one operation described by its go cycle, grantee and length.
    int         cyc = 0;
    bit         m_pend [4];
    logic [1:0] m_pos  [4];
    bit         m_active;
    int         m_go_cyc;
    int         m_g;
    int         m_len;
    int         m_rr;
    logic       m_item;
    logic       m_erase;
    logic [1:0] m_position;

    int exp_acks   = 0;
    int seen_acks  = 0;
    int dut_go_cyc = 0;
    int last_lat   = -1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", tag, cyc, observed, expected);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_pend[k] = 1'b0;
            m_pos[k]  = 2'd0;
        end
        m_active   = 1'b0;
        m_go_cyc   = 0;
        m_g        = 0;
        m_len      = 0;
        m_rr       = 0;
        m_item     = 1'b0;
        m_erase    = 1'b0;
        m_position = 2'd0;
    endtask

    function automatic bit model_any_pending();
        return m_pend[0] | m_pend[1] | m_pend[2] | m_pend[3];
    endfunction

    // Advance the model across one clock edge with the requests seen at that edge.
    task automatic model_edge(input logic [3:0] r, input logic [7:0] p);
        int gsel;
        int idx;
        cyc++;
        if (m_active && (cyc - 1) == m_go_cyc + m_len) begin
            m_active = 1'b0;
        end else if (!m_active && model_any_pending()) begin
            gsel = -1;
            for (int k = 0; k < 4; k++) begin
`ifdef DRAW_SCHED_RR_EN
                idx = (m_rr + k) % 4;
`else
                idx = k;
`endif
                if (gsel < 0 && m_pend[idx]) gsel = idx;
            end
            m_rr       = (gsel + 1) % 4;
            m_g        = gsel;
            m_active   = 1'b1;
            m_go_cyc   = cyc;
            m_len      = (gsel >= 2) ? PRESS_CYCLES : GARB_CYCLES;
            m_item     = (gsel >= 2);
            m_erase    = ((gsel % 2) == 0);
            m_position = m_pos[gsel];
            m_pend[gsel] = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            if (r[k]) begin
                m_pend[k] = 1'b1;
                m_pos[k]  = p[2*k +: 2];
            end
        end
    endtask

    task automatic check_cycle();
        logic [3:0] e_ack;
        logic       e_go;
        e_go  = m_active && (cyc == m_go_cyc);
        e_ack = (m_active && (cyc == m_go_cyc + m_len)) ? 4'(1 << m_g) : 4'd0;
        checkOutput("ack",  bus.ack,    e_ack);
        checkOutput("busy", bus.busy,   m_active);
        checkOutput("go",   bus.drw_go, e_go);
        checkOutput("drw",  {bus.drw_item, bus.drw_erase, bus.drw_position},
                            {m_item, m_erase, m_position});
        if (e_ack != 4'd0) exp_acks++;
        if (bus.ack != 4'd0) begin
            seen_acks++;
            last_lat = cyc - dut_go_cyc;
        end
        if (bus.drw_go) dut_go_cyc = cyc;
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_ack"},  bus.ack,    4'd0);
        checkOutput({tag, "_busy"}, bus.busy,   1'b0);
        checkOutput({tag, "_go"},   bus.drw_go, 1'b0);
        checkOutput({tag, "_drw"},  {bus.drw_item, bus.drw_erase, bus.drw_position}, 4'd0);
    endtask

    // One cycle: drive at the falling edge, clock, update model, check at next falling edge.
    task automatic applyStimulus(input logic [3:0] r, input logic [7:0] p);
        bus.req     = r;
        bus.req_pos = p;
        @(posedge CLOCK_50);
        model_edge(r, p);
        @(negedge CLOCK_50);
        check_cycle();
    endtask

    task automatic idle_steps(input int n);
        repeat (n) applyStimulus(4'd0, 8'd0);
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((m_active || model_any_pending()) && n < max_cycles) begin
            applyStimulus(4'd0, 8'd0);
            n++;
        end
        idle_steps(3);
        checkOutput("drain_idle", bus.busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] r;
        int n;
        bus.req     = 4'd0;
        bus.req_pos = 8'd0;
        model_reset();

        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check_reset_outputs("rst");
        reset = 1'b0;

        $display("[TB] single draw-press request at lane 2");
        applyStimulus(4'b1000, {2'd2, 6'd0});
        drain(3000);
        checkOutput("t1_latency", last_lat, PRESS_CYCLES);

        $display("[TB] simultaneous garbage draw and press erase");
        applyStimulus(4'b0110, {2'd0, 2'd3, 2'd1, 2'd0});
        drain(6000);

        $display("[TB] coalesced draw-press requests during a press erase");
        applyStimulus(4'b0100, 8'd0);
        idle_steps(5);
        applyStimulus(4'b1000, {2'd0, 6'd0});
        applyStimulus(4'b0000, 8'd0);
        applyStimulus(4'b1000, {2'd3, 6'd0});
        drain(6000);

        $display("[TB] reset in the middle of an operation");
        applyStimulus(4'b0010, {4'd0, 2'd2, 2'd0});
        n = 0;
        while (!m_active && n < 10) begin
            applyStimulus(4'd0, 8'd0);
            n++;
        end
        idle_steps(100);
        reset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;
        applyStimulus(4'b0001, {6'd0, 2'd1});
        drain(1000);
        checkOutput("t4_latency", last_lat, GARB_CYCLES);

        $display("[TB] re-request on the grant edge");
        applyStimulus(4'b0010, {4'd0, 2'd1, 2'd0});
        applyStimulus(4'b0010, {4'd0, 2'd3, 2'd0});
        drain(2000);

        $display("[TB] all requests held high");
        repeat (3000) applyStimulus(4'hF, 8'($urandom));
        drain(12000);

        $display("[TB] random sparse traffic");
        repeat (12000) begin
            for (int k = 0; k < 4; k++) r[k] = ($urandom_range(0, 399) == 0);
            applyStimulus(r, 8'($urandom));
        end
        drain(12000);

        checkOutput("ack_total", seen_acks, exp_acks);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
